mul16_sched: RTL and testbench
==============================

Name: mul16_sched

Overview:
- Round-robin scheduler that shares one pipelined signed Q0.15 multiplier (fixed latency MUL_LAT) among N_REQ requesters.
- Accepts operand pairs over valid/ready handshakes and issues at most one multiply per cycle.
- Tracks requester ID and precision through a tag pipeline, then returns the formatted result to the issuing requester.
- Sits between attention/MAC consumers and the shared multiplier instance.

Parameters:
- N_REQ, 4, number of requesters (2..8); ID_W = clog2(N_REQ) is a derived localparam.
- MUL_LAT, 4, cycles from mul_valid high to mul_result_valid high (1..8).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  grant enable; when low, no new grants are issued
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept
- req_a  in  16*N_REQ  operand A, signed Q0.15, slice i = [16i+15:16i]
- req_b  in  16*N_REQ  operand B, signed Q0.15
- req_prec  in  2*N_REQ  result format: 0=Q1.30, 1=Q1.14, 2=Q1.6, 3=reserved (treated as 0)
- mul_a  out  16  operand A to multiplier
- mul_b  out  16  operand B to multiplier
- mul_valid  out  1  issue strobe to multiplier
- mul_result  in  32  Q1.30 product from multiplier
- mul_result_valid  in  1  product valid
- resp_valid  out  N_REQ  one-hot response strobe
- resp_id  out  ID_W  requester ID of current response
- resp_data  out  32  formatted result
- in_flight  out  4  issued but not yet responded
- err  out  1  sticky tag/result mismatch flag

Behaviour:
- Reset: all outputs 0; RR pointer = N_REQ-1, so requester 0 has first priority; tag pipeline cleared. Reset mid-operation discards all in-flight work and produces no responses for it.
- Arbitration (combinational, same cycle):
  - Search starts at pointer+1 and wraps; the first requester with req_valid asserted wins.
  - req_ready[i] = en & grant[i]; at most one bit is set.
  - Transfer occurs when req_valid[i] & req_ready[i]. The pointer updates to i only on a transfer.
  - ready may depend on valid. Requesters must hold valid, a, b and prec stable until accepted, and must not wait on ready before asserting valid.
- Issue:
  - Transfer at clock edge T drives registered mul_a/mul_b/mul_valid=1 during cycle T+1.
  - With no transfer, mul_valid=0 and mul_a/mul_b hold their last values.
- Tag pipeline:
  - MUL_LAT-stage shift register of {valid, id, prec}, loaded with the issued tag in the cycle mul_valid=1.
  - The stage-MUL_LAT output aligns with mul_result_valid.
- Response (registered):
  - When mul_result_valid=1 and tag valid=1, the next cycle drives resp_valid = onehot(id), resp_id = id, resp_data = fmt(mul_result, prec).
  - End-to-end latency: transfer edge T → resp_valid high in cycle T+MUL_LAT+2.
  - Responses have no backpressure; requesters must accept them.
  - resp_data/resp_id hold their values when resp_valid=0.
- Formatting:
  - prec 0: mul_result unchanged.
  - prec 1: bits[30:15], sign-extended from bit 30 to 32.
  - prec 2: bits[30:23], sign-extended from bit 30.
  - Truncation, no rounding. The -1×-1 case (0x40000000) wraps for prec 1/2; this is documented and not saturated.
- in_flight:
  - +1 on each transfer, -1 on each resp_valid pulse; both in the same cycle leaves it unchanged.
  - Maximum MUL_LAT+2.
- err: set and held until reset when mul_result_valid differs from tag valid (either direction). On mismatch no response is generated.
- en low mid-stream: already-issued work completes and responds normally. Pending requesters stay not-ready.
- Back-to-back: one issue per cycle sustained; with N_REQ requesters all valid, each gets 1 of every N_REQ slots.

Test Plan:
- Single request on req 2, a=0x4000, b=0x4000, prec=0 → resp_valid=0b0100, resp_id=2, resp_data=0x10000000, MUL_LAT+2 cycles after transfer.
- Same operands with prec=1 → 0x00002000; with prec=2 → 0x00000020. Then a=0xC000, b=0x4000, prec=1 → 0xFFFFE000.
- All 4 requesters valid from reset and held → grant order 0,1,2,3,0,…; mul_valid high every cycle; in_flight peaks at MUL_LAT+2; responses return in the same order.
- Req 1 continuously valid, req 3 pulses valid once → req 3 granted within 2 cycles; pointer wraps 3→0 correctly.
- en=0 with all valid → req_ready=0, mul_valid=0; deassert en while 3 ops are in flight → all 3 responses still arrive and in_flight returns to 0.
- Force mul_result_valid=1 with an empty tag pipeline → err=1 and held, no resp_valid. Separately, assert rst_n low with 2 ops in flight → all outputs 0 and no responses after reset release.

Source files
------------

// File: rtl/mul16_sched.sv
// Round-robin front end sharing one pipelined Q0.15 multiplier among N_REQ
// requesters; tags ride alongside the multiplier and steer formatted results back.
module mul16_sched #(
    parameter int N_REQ   = 4,
    parameter int MUL_LAT = 4,
    localparam int ID_W   = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [16*N_REQ-1:0]  req_a,
    input  logic [16*N_REQ-1:0]  req_b,
    input  logic [2*N_REQ-1:0]   req_prec,
    output logic [15:0]          mul_a,
    output logic [15:0]          mul_b,
    output logic                 mul_valid,
    input  logic [31:0]          mul_result,
    input  logic                 mul_result_valid,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_data,
    output logic [3:0]           in_flight,
    output logic                 err
);

    logic [ID_W-1:0]  r_ptr;
    logic [15:0]      r_mul_a;
    logic [15:0]      r_mul_b;
    logic             r_mul_valid;
    logic [ID_W-1:0]  r_mul_id;
    logic [1:0]       r_mul_prec;
    logic             r_tv    [MUL_LAT];
    logic [ID_W-1:0]  r_tid   [MUL_LAT];
    logic [1:0]       r_tprec [MUL_LAT];
    logic [N_REQ-1:0] r_resp_valid;
    logic [ID_W-1:0]  r_resp_id;
    logic [31:0]      r_resp_data;
    logic [3:0]       r_inflight;
    logic             r_err;

    logic [N_REQ-1:0] w_grant;
    logic [ID_W-1:0]  w_gid;
    logic             w_found;
    logic             w_xfer;
    logic             w_tag_v;
    logic [ID_W-1:0]  w_tag_id;
    logic [1:0]       w_tag_prec;
    logic [31:0]      w_fmt;
    logic [N_REQ-1:0] w_onehot;

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_grant = '0;
        w_gid   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found      = 1'b1;
                w_grant[idx] = 1'b1;
                w_gid        = ID_W'(idx);
            end
        end
    end

    assign w_xfer    = en & w_found;
    assign req_ready = en ? w_grant : '0;

    assign w_tag_v    = r_tv[MUL_LAT-1];
    assign w_tag_id   = r_tid[MUL_LAT-1];
    assign w_tag_prec = r_tprec[MUL_LAT-1];

    always_comb begin
        w_fmt = mul_result;
        unique case (1'b1)
            (w_tag_prec == 2'd1): w_fmt = {{16{mul_result[30]}}, mul_result[30:15]};
            (w_tag_prec == 2'd2): w_fmt = {{24{mul_result[30]}}, mul_result[30:23]};
            default: ;
        endcase
    end

    always_comb begin
        w_onehot = '0;
        w_onehot[w_tag_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= ID_W'(N_REQ - 1);
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mul_valid <= 1'b0;
            r_mul_id    <= '0;
            r_mul_prec  <= '0;
        end else begin
            r_mul_valid <= w_xfer;
            if (w_xfer) begin
                r_ptr      <= w_gid;
                r_mul_a    <= req_a[{w_gid, 4'b0} +: 16];
                r_mul_b    <= req_b[{w_gid, 4'b0} +: 16];
                r_mul_id   <= w_gid;
                r_mul_prec <= req_prec[{w_gid, 1'b0} +: 2];
            end
        end
    end

    // Tag shift register mirrors the multiplier latency stage for stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MUL_LAT; s++) begin
                r_tv[s]    <= 1'b0;
                r_tid[s]   <= '0;
                r_tprec[s] <= '0;
            end
        end else begin
            r_tv[0]    <= r_mul_valid;
            r_tid[0]   <= r_mul_id;
            r_tprec[0] <= r_mul_prec;
            for (int s = 1; s < MUL_LAT; s++) begin
                r_tv[s]    <= r_tv[s-1];
                r_tid[s]   <= r_tid[s-1];
                r_tprec[s] <= r_tprec[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= '0;
            r_resp_id    <= '0;
            r_resp_data  <= '0;
            r_inflight   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            if (mul_result_valid && w_tag_v) begin
                r_resp_valid <= w_onehot;
                r_resp_id    <= w_tag_id;
                r_resp_data  <= w_fmt;
            end
            if (mul_result_valid != w_tag_v) r_err <= 1'b1;
            r_inflight <= r_inflight + {3'b0, w_xfer} - {3'b0, |r_resp_valid};
        end
    end

    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign mul_valid  = r_mul_valid;
    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign in_flight  = r_inflight;
    assign err        = r_err;

endmodule

// File: tb/tb_mul16_sched.sv
// Directed bench for mul16_sched with a behavioural pipelined multiplier.
module tb_mul16_sched;

    localparam int N = 4;
    localparam int L = 4;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic [2*N-1:0]  req_prec;
    logic [15:0]   mul_a;
    logic [15:0]   mul_b;
    logic          mul_valid;
    logic [31:0]   mul_result;
    logic          mul_result_valid;
    logic [N-1:0]  resp_valid;
    logic [1:0]    resp_id;
    logic [31:0]   resp_data;
    logic [3:0]    in_flight;
    logic          err;
    logic          force_rv;

    int n_chk = 0;
    int n_err = 0;

    mul16_sched #(.N_REQ(N), .MUL_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_prec(req_prec),
        .mul_a(mul_a), .mul_b(mul_b), .mul_valid(mul_valid),
        .mul_result(mul_result), .mul_result_valid(mul_result_valid),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .in_flight(in_flight), .err(err)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // External multiplier: fixed latency L, Q0.15 x Q0.15 -> Q1.30.
    logic [31:0] m_prod [L];
    logic        m_v    [L];

    function automatic logic [31:0] mulq(input logic [15:0] a, input logic [15:0] b);
        logic signed [31:0] x;
        logic signed [31:0] y;
        x = {{16{a[15]}}, a};
        y = {{16{b[15]}}, b};
        return x * y;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < L; s++) begin
                m_v[s]    <= 1'b0;
                m_prod[s] <= '0;
            end
        end else begin
            m_v[0]    <= mul_valid;
            m_prod[0] <= mulq(mul_a, mul_b);
            for (int s = 1; s < L; s++) begin
                m_v[s]    <= m_v[s-1];
                m_prod[s] <= m_prod[s-1];
            end
        end
    end

    assign mul_result       = m_prod[L-1];
    assign mul_result_valid = m_v[L-1] | force_rv;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  p;
        logic [31:0] exp;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [15:0] a,
                           input logic [15:0] b, input logic [1:0] p);
        req_a[id*16 +: 16] = a;
        req_b[id*16 +: 16] = b;
        req_prec[id*2 +: 2] = p;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_mul"}, {31'b0, mul_valid, mul_a, mul_b}, 64'd0);
        chk({nm, "_resp"}, {26'b0, resp_valid, resp_id, resp_data}, 64'd0);
        chk({nm, "_misc"}, {55'b0, in_flight, err, req_ready}, 64'd0);
    endtask

    task automatic do_reset;
        rst_n     = 0;
        en        = 1;
        force_rv  = 0;
        req_valid = '0;
        repeat (2) cyc();
        rst_n = 1;
        cyc();
    endtask

    initial begin
        logic [N-1:0] oh;
        int rcnt;
        int w;

        rst_n = 0; en = 1; force_rv = 0;
        req_valid = '0; req_a = '0; req_b = '0; req_prec = '0;

        vt[0]  = '{2, 16'h4000, 16'h4000, 2'd0, 32'h1000_0000};
        vt[1]  = '{2, 16'h4000, 16'h4000, 2'd1, 32'h0000_2000};
        vt[2]  = '{2, 16'h4000, 16'h4000, 2'd2, 32'h0000_0020};
        vt[3]  = '{2, 16'hC000, 16'h4000, 2'd1, 32'hFFFF_E000};
        vt[4]  = '{0, 16'h8000, 16'h8000, 2'd0, 32'h4000_0000};
        vt[5]  = '{0, 16'h8000, 16'h8000, 2'd1, 32'hFFFF_8000};
        vt[6]  = '{1, 16'h8000, 16'h8000, 2'd2, 32'hFFFF_FF80};
        vt[7]  = '{3, 16'h4000, 16'h4000, 2'd3, 32'h1000_0000};
        vt[8]  = '{1, 16'h7FFF, 16'h7FFF, 2'd1, 32'h0000_7FFE};
        vt[9]  = '{3, 16'h8000, 16'h7FFF, 2'd2, 32'hFFFF_FF80};
        vt[10] = '{0, 16'hFFFF, 16'h0001, 2'd0, 32'hFFFF_FFFF};

        repeat (2) cyc();
        chk_zero("reset");
        rst_n = 1;
        cyc();

        // Single requests: latency, formatting and one-hot steering.
        for (int i = 0; i < 11; i++) begin
            oh = '0;
            oh[vt[i].id] = 1'b1;
            set_req(vt[i].id, vt[i].a, vt[i].b, vt[i].p);
            req_valid = oh;
            #1;
            chk($sformatf("v%0d_ready", i), 64'(req_ready), 64'(oh));
            cyc();
            req_valid = '0;
            chk($sformatf("v%0d_issue", i), {31'b0, mul_valid, mul_a, mul_b},
                {31'b0, 1'b1, vt[i].a, vt[i].b});
            chk($sformatf("v%0d_inflight1", i), 64'(in_flight), 64'd1);
            repeat (L) cyc();
            chk($sformatf("v%0d_early", i), 64'(resp_valid), 64'd0);
            cyc();
            chk($sformatf("v%0d_resp", i), {26'b0, resp_valid, resp_id, resp_data},
                {26'b0, oh, 2'(vt[i].id), vt[i].exp});
            cyc();
            chk($sformatf("v%0d_hold", i), {27'b0, resp_valid, in_flight, resp_data},
                {27'b0, 4'b0, 4'd0, vt[i].exp});
        end

        // All requesters held valid: strict rotation, full throughput.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'(32'h1000 * (i + 1)), 16'h4000, 2'd0);
        req_valid = '1;
        rcnt = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            oh = '0;
            oh[k % N] = 1'b1;
            chk($sformatf("rr_grant%0d", k), 64'(req_ready), 64'(oh));
            if (k >= 1) chk($sformatf("rr_mulv%0d", k), 64'(mul_valid), 64'd1);
            if (k == L + 2 || k == 15)
                chk($sformatf("rr_peak%0d", k), 64'(in_flight), 64'(L + 2));
            if (resp_valid != '0) begin
                chk($sformatf("rr_resp%0d", rcnt), {30'b0, resp_id, resp_data},
                    {30'b0, 2'(rcnt % N), 32'h0400_0000 * 32'(rcnt % N + 1)});
                rcnt++;
            end
            cyc();
        end
        chk("rr_count", 64'(rcnt), 64'd10);

        // Late requester 3 is served promptly, then the pointer wraps.
        do_reset();
        set_req(1, 16'h1000, 16'h1000, 2'd0);
        set_req(3, 16'h2000, 16'h1000, 2'd0);
        set_req(0, 16'h3000, 16'h1000, 2'd0);
        req_valid = 4'b0010;
        #1;
        chk("pulse_r1", 64'(req_ready), 64'h2);
        cyc();
        req_valid = 4'b1010;
        #1;
        w = 0;
        while (!req_ready[3] && w < 2) begin
            cyc();
            w++;
        end
        chk("pulse_r3", 64'(req_ready), 64'h8);
        cyc();
        req_valid = 4'b0010;
        #1;
        chk("wrap_r1", 64'(req_ready), 64'h2);
        req_valid = 4'b0011;
        #1;
        chk("wrap_r0", 64'(req_ready), 64'h1);
        req_valid = '0;

        // Grants stop with en low; issued work still drains.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 16'h0800, 16'h0800, 2'd1);
        req_valid = '1;
        repeat (3) cyc();
        en = 0;
        #1;
        chk("en_ready", 64'(req_ready), 64'd0);
        cyc();
        chk("en_mulv", 64'(mul_valid), 64'd0);
        chk("en_inflight", 64'(in_flight), 64'd3);
        rcnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid != '0) rcnt++;
            cyc();
        end
        chk("en_resp_cnt", 64'(rcnt), 64'd3);
        chk("en_drained", {59'b0, mul_valid, in_flight}, 64'd0);
        req_valid = '0;
        en = 1;

        // Result without a tag: sticky error, no response.
        do_reset();
        force_rv = 1;
        cyc();
        force_rv = 0;
        chk("err_set", {59'b0, err, resp_valid}, {59'b0, 1'b1, 4'b0});
        repeat (3) cyc();
        chk("err_held", {59'b0, err, resp_valid}, {59'b0, 1'b1, 4'b0});

        // Reset with work in flight discards it.
        do_reset();
        set_req(0, 16'h4000, 16'h4000, 2'd0);
        set_req(1, 16'h4000, 16'h2000, 2'd0);
        req_valid = 4'b0011;
        repeat (2) cyc();
        chk("mid_inflight", 64'(in_flight), 64'd2);
        req_valid = '0;
        rst_n = 0;
        #1;
        chk_zero("mid_rst");
        cyc();
        rst_n = 1;
        rcnt = 0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (resp_valid != '0) rcnt++;
        end
        chk("mid_noresp", 64'(rcnt), 64'd0);
        chk("mid_state", {59'b0, err, in_flight}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
